// File: rtl/cc_gen_if.sv
// Pipeline-side bundle for the condition-code producer: EX capture fields,
// the memory return path and the forwarded nzp/stall outputs.
interface cc_gen_if #(
   parameter int WIDTH = 16
);
   logic             advance;
   logic             flush;
   logic             ex_valid;
   logic             ex_setcc;
   logic [WIDTH-1:0] ex_result;
   logic [1:0]       ex_load_kind;
   logic             ex_byte;
   logic             ex_addr0;
   logic             mem_resp;
   logic [WIDTH-1:0] mem_rdata;
   logic [2:0]       cc;
   logic [2:0]       mem_nzp;
   logic             mem_nzp_fwd;
   logic             cc_pending;
   logic             mem_busy;

   // Pipeline control / memory model side.
   modport master (
      output advance, flush, ex_valid, ex_setcc, ex_result, ex_load_kind,
             ex_byte, ex_addr0, mem_resp, mem_rdata,
      input  cc, mem_nzp, mem_nzp_fwd, cc_pending, mem_busy
   );

   // Condition-code generator side.
   modport slave (
      input  advance, flush, ex_valid, ex_setcc, ex_result, ex_load_kind,
             ex_byte, ex_addr0, mem_resp, mem_rdata,
      output cc, mem_nzp, mem_nzp_fwd, cc_pending, mem_busy
   );
endinterface

// File: rtl/cc_gen.sv
// LC-3b condition-code producer: carries CC setters from EX through MEM to
// WB, resolves load nzp from memory return data, holds the architectural CC
// and forwards the youngest known nzp to the branch comparator.
module cc_gen #(
   parameter int         WIDTH    = 16,
   parameter logic [2:0] RESET_CC = 3'b010
) (
   input logic      clk,
   input logic      reset_n,
   cc_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_DONE  = 2'd0,
      ST_WAIT1 = 2'd1,
      ST_WAIT2 = 2'd2
   } mem_st_t;

   // One-hot {n,z,p} classification of a datapath word.
   function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] x);
      logic n, z;
      n = x[WIDTH-1];
      z = (x == '0);
      return {n, z, ~n & ~z};
   endfunction

   // MEM stage
   logic       m_v, m_set, m_addr0, m_byte;
   logic [2:0] m_nzp;
   mem_st_t    m_st;
   // WB stage
   logic       w_v, w_set;
   logic [2:0] w_nzp;
   // Architectural CC
   logic [2:0] cc_q;

   logic             busy;
   logic             adv;
   logic             capture;
   logic [7:0]       rbyte;
   logic [WIDTH-1:0] load_val;

   assign busy    = m_v & (m_st != ST_DONE);
   // A stalled MEM load swallows any advance request until its data returns.
   assign adv     = bus.advance & ~busy;
   assign capture = bus.ex_valid & ~bus.flush;

   // Load return word as seen by the CC logic (LDB picks and sign-extends a byte).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      rbyte    = m_addr0 ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
      load_val = bus.mem_rdata;
      if (m_byte)
         load_val = {{(WIDTH-8){rbyte[7]}}, rbyte};
   end

   // Pipeline registers, MEM load FSM and CC commit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_v     <= 1'b0;
         m_set   <= 1'b0;
         m_nzp   <= 3'b000;
         m_addr0 <= 1'b0;
         m_byte  <= 1'b0;
         m_st    <= ST_DONE;
         w_v     <= 1'b0;
         w_set   <= 1'b0;
         w_nzp   <= 3'b000;
         cc_q    <= RESET_CC;
      end else begin
         // NOTE: non-blocking assignments make every stage read the pre-edge
         // value of its predecessor, so commit sees the old W while W loads M.
         if (w_v && w_set)
            cc_q <= w_nzp;

         if (adv) begin
            w_v   <= m_v;
            w_set <= m_set;
            w_nzp <= m_nzp;
            if (capture) begin
               m_v     <= 1'b1;
               m_set   <= bus.ex_setcc;
               m_addr0 <= bus.ex_addr0;
               m_byte  <= bus.ex_byte;
               unique case (bus.ex_load_kind)
                  2'b00: begin
                     m_st  <= ST_DONE;
                     m_nzp <= nzp_of(bus.ex_result);
                  end
                  2'b10: begin
                     m_st  <= ST_WAIT2;
                     m_nzp <= 3'b000;
                  end
                  default: begin
                     m_st  <= ST_WAIT1;
                     m_nzp <= 3'b000;
                  end
               endcase
            end else begin
               m_v  <= 1'b0;
               m_st <= ST_DONE;
            end
         end else if (busy && bus.mem_resp) begin
            unique case (m_st)
               ST_WAIT2: m_st <= ST_WAIT1;
               ST_WAIT1: begin
                  m_st  <= ST_DONE;
                  m_nzp <= nzp_of(load_val);
               end
               default:  m_st <= m_st;
            endcase
         end
      end
   end

   // Youngest-first forwarding of the effective nzp to the branch unit.
   always_comb begin
      bus.mem_nzp     = cc_q;
      bus.mem_nzp_fwd = 1'b0;
      bus.cc_pending  = 1'b0;
      if (m_v && m_set) begin
         bus.mem_nzp_fwd = 1'b1;
         if (m_st == ST_DONE) begin
            bus.mem_nzp = m_nzp;
         end else begin
            bus.mem_nzp    = 3'b000;
            bus.cc_pending = 1'b1;
         end
      end else if (w_v && w_set) begin
         bus.mem_nzp     = w_nzp;
         bus.mem_nzp_fwd = 1'b1;
      end
   end

   assign bus.cc       = cc_q;
   assign bus.mem_busy = busy;

endmodule

// File: tb/tb_cc_gen.sv
// Bench for cc_gen: directed scenarios with literal expectations followed by
// randomized traffic, all compared every cycle against an in-flight list model.
module tb_cc_gen;
   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cc_gen_if #(.WIDTH(WIDTH)) bus ();

   cc_gen #(.WIDTH(WIDTH), .RESET_CC(3'b010)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int proto_errs = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // An instruction in flight: how many memory accesses it still needs and
   // the nzp it will deliver once all of them have returned.
   typedef struct {
      bit         v;
      bit         set;
      int         left;
      bit         byte_ld;
      bit         addr0;
      logic [2:0] nzp;
   } ent_t;

   ent_t       mq, wq;     // older-to-younger: wq then mq
   logic [2:0] m_cc;

   function automatic logic [2:0] classify(input int signed v);
      if (v < 0)       return 3'b100;
      else if (v == 0) return 3'b010;
      else             return 3'b001;
   endfunction

   function automatic logic [2:0] word_nzp(input logic [15:0] x);
      int signed v;
      v = $signed(x);
      return classify(v);
   endfunction

   function automatic logic [2:0] load_nzp(input logic [15:0] d, input bit b, input bit a0);
      logic [7:0] by;
      int signed  v;
      if (!b) return word_nzp(d);
      by = a0 ? d[15:8] : d[7:0];
      v  = $signed(by);
      return classify(v);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      bit busy_now;
      if (!reset_n) begin
         mq   = '{v: 0, set: 0, left: 0, byte_ld: 0, addr0: 0, nzp: 3'b000};
         wq   = mq;
         m_cc = 3'b010;
      end else begin
         busy_now = mq.v && (mq.left > 0);
         if (bus.advance && busy_now) proto_errs++;
         if (wq.v && wq.set) m_cc = wq.nzp;
         if (bus.advance && !busy_now) begin
            wq = mq;
            if (bus.ex_valid && !bus.flush) begin
               mq.v       = 1;
               mq.set     = bus.ex_setcc;
               mq.byte_ld = bus.ex_byte;
               mq.addr0   = bus.ex_addr0;
               mq.left    = (bus.ex_load_kind == 2'b00) ? 0 :
                            (bus.ex_load_kind == 2'b10) ? 2 : 1;
               mq.nzp     = (mq.left == 0) ? word_nzp(bus.ex_result) : 3'b000;
            end else begin
               mq.v    = 0;
               mq.left = 0;
            end
         end else if (bus.mem_resp && busy_now) begin
            mq.left--;
            if (mq.left == 0) mq.nzp = load_nzp(bus.mem_rdata, mq.byte_ld, mq.addr0);
         end
      end
   end

   // Single compare process: outputs against the model, every cycle.
   always @(negedge clk) begin
      logic [2:0] e_nzp;
      logic       e_fwd, e_pend, e_busy;
      e_busy = mq.v && (mq.left > 0);
      e_pend = 1'b0;
      if (mq.v && mq.set) begin
         e_fwd  = 1'b1;
         e_pend = (mq.left > 0);
         e_nzp  = e_pend ? 3'b000 : mq.nzp;
      end else if (wq.v && wq.set) begin
         e_fwd = 1'b1;
         e_nzp = wq.nzp;
      end else begin
         e_fwd = 1'b0;
         e_nzp = m_cc;
      end
      check("cmp_cc",      16'(bus.cc),          16'(m_cc));
      check("cmp_mem_nzp", 16'(bus.mem_nzp),     16'(e_nzp));
      check("cmp_fwd",     16'(bus.mem_nzp_fwd), 16'(e_fwd));
      check("cmp_pending", 16'(bus.cc_pending),  16'(e_pend));
      check("cmp_busy",    16'(bus.mem_busy),    16'(e_busy));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.advance      = 1'b0;
      bus.flush        = 1'b0;
      bus.ex_valid     = 1'b0;
      bus.ex_setcc     = 1'b0;
      bus.ex_result    = '0;
      bus.ex_load_kind = 2'b00;
      bus.ex_byte      = 1'b0;
      bus.ex_addr0     = 1'b0;
      bus.mem_resp     = 1'b0;
      bus.mem_rdata    = '0;
   endtask

   task automatic ex_op(input bit set, input logic [15:0] res, input logic [1:0] kind,
                        input bit b, input bit a0);
      bus.ex_valid     = 1'b1;
      bus.ex_setcc     = set;
      bus.ex_result    = res;
      bus.ex_load_kind = kind;
      bus.ex_byte      = b;
      bus.ex_addr0     = a0;
   endtask

   task automatic outs(input string tag, input logic [2:0] nzp, input bit fwd,
                       input bit pend, input bit busy);
      check({tag, "_nzp"},  16'(bus.mem_nzp),     16'(nzp));
      check({tag, "_fwd"},  16'(bus.mem_nzp_fwd), 16'(fwd));
      check({tag, "_pend"}, 16'(bus.cc_pending),  16'(pend));
      check({tag, "_busy"}, 16'(bus.mem_busy),    16'(busy));
   endtask

   initial begin
      idle_inputs();
      repeat (3) tick();
      reset_n = 1'b1;

      // Idle after reset
      repeat (4) tick();
      check("rst_cc", 16'(bus.cc), 16'h0002);
      outs("rst", 3'b010, 0, 0, 0);

      // ADD setting N, walked to commit
      ex_op(1, 16'h8000, 2'b00, 0, 0);
      bus.advance = 1'b1;
      tick();
      bus.ex_valid = 1'b0;
      outs("add_e1", 3'b100, 1, 0, 0);
      tick();
      outs("add_e2", 3'b100, 1, 0, 0);
      check("add_e2_cc", 16'(bus.cc), 16'h0002);
      tick();
      outs("add_e3", 3'b100, 0, 0, 0);
      check("add_e3_cc", 16'(bus.cc), 16'h0004);

      // LDB high byte, advance held while waiting
      ex_op(1, 16'h0000, 2'b01, 1, 1);
      tick();
      bus.ex_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         outs("ldb_wait", 3'b000, 1, 1, 1);
         tick();
      end
      outs("ldb_wait3", 3'b000, 1, 1, 1);
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 16'h80FF;
      tick();
      bus.mem_resp = 1'b0;
      outs("ldb_done", 3'b100, 1, 0, 0);
      bus.advance = 1'b0;
      tick();

      // LDI: pointer, then data
      ex_op(1, 16'h0000, 2'b10, 0, 0);
      bus.advance = 1'b1;
      tick();
      bus.ex_valid = 1'b0;
      bus.advance  = 1'b0;
      bus.mem_resp = 1'b1;
      bus.mem_rdata = 16'h0000;
      tick();
      outs("ldi_ptr", 3'b000, 1, 1, 1);
      bus.mem_rdata = 16'h0005;
      tick();
      bus.mem_resp = 1'b0;
      outs("ldi_data", 3'b001, 1, 0, 0);
      bus.advance = 1'b1;
      repeat (2) tick();
      check("ldi_cc", 16'(bus.cc), 16'h0001);

      // Priority: M setter over W setter, then M non-setter exposes W
      ex_op(1, 16'h8000, 2'b00, 0, 0);
      tick();
      ex_op(1, 16'h0000, 2'b00, 0, 0);
      tick();
      check("prio_m_over_w", 16'(bus.mem_nzp), 16'h0002);
      ex_op(1, 16'hFFFF, 2'b00, 0, 0);
      tick();
      ex_op(0, 16'h0000, 2'b00, 0, 0);
      tick();
      check("prio_w_when_m_noset", 16'(bus.mem_nzp), 16'h0004);
      bus.ex_valid = 1'b0;
      repeat (2) tick();
      check("drain_cc", 16'(bus.cc), 16'h0004);

      // Flush: squashed capture leaves CC visible
      ex_op(1, 16'h0001, 2'b00, 0, 0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      outs("flush", 3'b100, 0, 0, 0);

      // Reset in the middle of an LDI wait
      ex_op(1, 16'h0000, 2'b10, 0, 0);
      tick();
      bus.ex_valid = 1'b0;
      bus.advance  = 1'b0;
      check("ldi2_busy", 16'(bus.mem_busy), 16'h0001);
      #2 reset_n = 1'b0;
      #1;
      outs("midrst", 3'b010, 0, 0, 0);
      check("midrst_cc", 16'(bus.cc), 16'h0002);
      tick();
      reset_n = 1'b1;
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 16'h8000;
      tick();
      bus.mem_resp = 1'b0;
      outs("late_resp", 3'b010, 0, 0, 0);
      check("late_resp_cc", 16'(bus.cc), 16'h0002);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] r;
         case ($urandom_range(0, 3))
            0:       r = 16'h0000;
            1:       r = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            default: r = 16'($urandom);
         endcase
         bus.advance      = ($urandom_range(0, 3) != 0);
         bus.flush        = ($urandom_range(0, 7) == 0);
         bus.ex_valid     = ($urandom_range(0, 3) != 0);
         bus.ex_setcc     = ($urandom_range(0, 3) != 0);
         bus.ex_result    = r;
         bus.ex_load_kind = 2'($urandom_range(0, 3));
         bus.ex_byte      = 1'($urandom_range(0, 1));
         bus.ex_addr0     = 1'($urandom_range(0, 1));
         bus.mem_resp     = ($urandom_range(0, 2) == 0);
         bus.mem_rdata    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         tick();
      end

      idle_inputs();
      repeat (2) tick();
      $display("protocol note: %0d advance requests issued while busy", proto_errs);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
